// File: rtl/rp2serial.sv
// rp2serial: region-proposal to bit-serial bridge.
//
// A batch of bounding-box corner pairs is captured from the RP block into a
// small register buffer. Each region is then streamed to the CNN side as two
// serial lines (x and y) paced by a clk/2 region clock.
//
// RP capture handshake: the RP offers a batch by raising region_valid with a
// non-zero num_obj and word 0 on region_x/region_y. The bridge answers with
// region_rd_en one edge later. Every edge that sees region_rd_en=1 and
// region_valid=1 consumes the presented word, and the RP presents the next
// word on the following cycle. region_valid low while region_rd_en is high
// ends the batch early.
//
// Optional build macro: RP2SERIAL_SORT_CORNERS_EN -- when defined, each region
// is normalised on capture so corner 1 holds the minimum x/y and corner 2 the
// maximum x/y.
module rp2serial #(
  parameter int MAX_NUM_OBJ = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reset_new,
  input  logic [4:0] num_obj,
  input  logic [8:0] region_x,
  input  logic [8:0] region_y,
  input  logic       region_valid,
  output logic       region_rd_en,
  input  logic       cnn_rd_region,
  output logic       cnn_region_done,
  output logic       cnn_region_valid,
  output logic       cnn_region_x_bit,
  output logic       cnn_region_y_bit,
  output logic       cnn_region_clk
);

  localparam int DEPTH = 2 * MAX_NUM_OBJ;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [5:0] MAX6   = 6'(MAX_NUM_OBJ);
  localparam logic [5:0] DEPTH6 = 6'(DEPTH);

  typedef enum logic {L_IDLE, L_CAPTURE} l_state_e;
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} s_state_e;

  // region clock divider
  logic clk_div_q, clk_div_d;

  // loader state
  l_state_e   l_state_q, l_state_d;
  logic       rd_en_q, rd_en_d;
  logic [5:0] wcnt_q, wcnt_d;   // words consumed in this batch
  logic [5:0] tgt_q, tgt_d;     // 2*num_obj words expected
  logic [5:0] n_q, n_d;         // regions that fit in the buffer
  logic [17:0] mem_q [DEPTH];
  logic [17:0] mem_d [DEPTH];

  // serializer state
  s_state_e    s_state_q, s_state_d;
  logic [4:0]  bit_q, bit_d;
  logic [17:0] sx_q, sx_d;
  logic [17:0] sy_q, sy_d;
  logic        valid_q, valid_d;
  logic        xb_q, xb_d;
  logic        yb_q, yb_d;
  logic        done_q, done_d;
  logic [5:0]  cnt_q, cnt_d;    // regions available to send
  logic [5:0]  rp_q, rp_d;      // next region to send

  // loader -> serializer events
  logic       load_start;
  logic       load_done;
  logic [5:0] load_cnt;

  logic        upd;
  logic        start_ok;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_a;
  logic [AW-1:0] rd_b;
  logic [17:0] c1;
  logic [17:0] c2;
  logic [5:0]  pairs;

  // The update slot is the edge where the region clock falls.
  assign upd    = clk_div_q;
  assign wr_idx = wcnt_q[AW-1:0];
  assign rd_a   = {rp_q[AW-2:0], 1'b0};
  assign rd_b   = {rp_q[AW-2:0], 1'b1};
  assign c1     = mem_q[rd_a];
  assign c2     = mem_q[rd_b];
  assign pairs  = {1'b0, wcnt_q[5:1]};

  assign region_rd_en     = rd_en_q;
  assign cnn_region_done  = done_q;
  assign cnn_region_valid = valid_q;
  assign cnn_region_x_bit = xb_q;
  assign cnn_region_y_bit = yb_q;
  assign cnn_region_clk   = clk_div_q;

  // Region clock: free-running toggle, only stopped by the full reset.
  always_comb begin
    clk_div_d = ~clk_div_q;
  end

  // Loader: grant a batch when the serializer is idle, then capture words.
  always_comb begin
    l_state_d  = l_state_q;
    rd_en_d    = rd_en_q;
    wcnt_d     = wcnt_q;
    tgt_d      = tgt_q;
    n_d        = n_q;
    mem_d      = mem_q;
    load_start = 1'b0;
    load_done  = 1'b0;
    load_cnt   = '0;
    case (l_state_q)
      L_IDLE: begin
        if (region_valid && (num_obj != 5'd0) && (s_state_q == S_IDLE)) begin
          load_start = 1'b1;
          l_state_d  = L_CAPTURE;
          rd_en_d    = 1'b1;
          wcnt_d     = '0;
          tgt_d      = {num_obj, 1'b0};
          n_d        = ({1'b0, num_obj} > MAX6) ? MAX6 : {1'b0, num_obj};
        end
      end
      L_CAPTURE: begin
        if (region_valid) begin
          // Words past the buffer depth are consumed but dropped.
          if (wcnt_q < DEPTH6) begin
            mem_d[wr_idx] = {region_x, region_y};
`ifdef RP2SERIAL_SORT_CORNERS_EN
            if (wcnt_q[0]) begin
              logic [AW-1:0] pair_idx;
              logic [8:0]    px;
              logic [8:0]    py;
              pair_idx = {wr_idx[AW-1:1], 1'b0};
              px       = mem_q[pair_idx][17:9];
              py       = mem_q[pair_idx][8:0];
              mem_d[pair_idx] = {((px < region_x) ? px : region_x),
                                 ((py < region_y) ? py : region_y)};
              mem_d[wr_idx]   = {((px < region_x) ? region_x : px),
                                 ((py < region_y) ? region_y : py)};
            end
`endif
          end
          wcnt_d = 6'(wcnt_q + 6'd1);
          if (6'(wcnt_q + 6'd1) == tgt_q) begin
            load_done = 1'b1;
            load_cnt  = n_q;
          end
        end else begin
          // RP stopped early: keep only the complete corner pairs.
          load_done = 1'b1;
          load_cnt  = (pairs > n_q) ? n_q : pairs;
        end
        if (load_done) begin
          l_state_d = L_IDLE;
          rd_en_d   = 1'b0;
        end
      end
      default: l_state_d = L_IDLE;
    endcase
  end

  // Serializer: one bit per region-clock period, changing only in update slots.
  always_comb begin
    s_state_d = s_state_q;
    bit_d     = bit_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    valid_d   = valid_q;
    xb_d      = xb_q;
    yb_d      = yb_q;
    done_d    = done_q;
    cnt_d     = cnt_q;
    rp_d      = rp_q;
    start_ok  = cnn_rd_region && (rp_q < cnt_q) && !load_start;
    if (upd) begin
      case (s_state_q)
        // The gap period ends at the next slot, which may start the next
        // region directly so back-to-back regions take 19 periods.
        S_IDLE, S_GAP: begin
          if (start_ok) begin
            s_state_d = S_SEND;
            bit_d     = '0;
            valid_d   = 1'b1;
            xb_d      = c1[17];
            yb_d      = c1[8];
            sx_d      = {c1[16:9], c2[17:9], 1'b0};
            sy_d      = {c1[7:0], c2[8:0], 1'b0};
          end else begin
            s_state_d = S_IDLE;
          end
        end
        S_SEND: begin
          if (bit_q == 5'd17) begin
            s_state_d = S_GAP;
            valid_d   = 1'b0;
            xb_d      = 1'b0;
            yb_d      = 1'b0;
            rp_d      = 6'(rp_q + 6'd1);
            if (6'(rp_q + 6'd1) == cnt_q) done_d = 1'b1;
          end else begin
            bit_d = 5'(bit_q + 5'd1);
            xb_d  = sx_q[17];
            yb_d  = sy_q[17];
            sx_d  = {sx_q[16:0], 1'b0};
            sy_d  = {sy_q[16:0], 1'b0};
          end
        end
        default: s_state_d = S_IDLE;
      endcase
    end
    // A new batch empties the buffer until its capture completes.
    if (load_start) begin
      cnt_d  = '0;
      rp_d   = '0;
      done_d = 1'b1;
    end
    if (load_done) begin
      cnt_d  = load_cnt;
      rp_d   = '0;
      done_d = (load_cnt == 6'd0);
    end
  end

  // Divider register: only the full reset stops it.
  always_ff @(posedge clk) begin
    if (reset) clk_div_q <= 1'b0;
    else       clk_div_q <= clk_div_d;
  end

  // Control registers: full or soft reset aborts capture and send.
  always_ff @(posedge clk) begin
    if (reset || reset_new) begin
      l_state_q <= L_IDLE;
      rd_en_q   <= 1'b0;
      wcnt_q    <= '0;
      tgt_q     <= '0;
      n_q       <= '0;
      s_state_q <= S_IDLE;
      bit_q     <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      valid_q   <= 1'b0;
      xb_q      <= 1'b0;
      yb_q      <= 1'b0;
      done_q    <= 1'b1;
      cnt_q     <= '0;
      rp_q      <= '0;
    end else begin
      l_state_q <= l_state_d;
      rd_en_q   <= rd_en_d;
      wcnt_q    <= wcnt_d;
      tgt_q     <= tgt_d;
      n_q       <= n_d;
      s_state_q <= s_state_d;
      bit_q     <= bit_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      valid_q   <= valid_d;
      xb_q      <= xb_d;
      yb_q      <= yb_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      rp_q      <= rp_d;
    end
  end

  // Region buffer: contents are meaningless once the count is cleared.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_rp2serial.sv
// Directed bench for rp2serial: reset/idle, batch load, serial bursts,
// empty requests, corner ordering, soft reset and buffer-depth overflow.
module tb_rp2serial;

  logic       clk;
  logic       reset;
  logic       reset_new;
  logic [4:0] num_obj;
  logic [8:0] region_x;
  logic [8:0] region_y;
  logic       region_valid;
  logic       region_rd_en;
  logic       cnn_rd_region;
  logic       cnn_region_done;
  logic       cnn_region_valid;
  logic       cnn_region_x_bit;
  logic       cnn_region_y_bit;
  logic       cnn_region_clk;

  int total;
  int bad;

  logic [8:0] wx [64];
  logic [8:0] wy [64];

  rp2serial dut (
    .clk              (clk),
    .reset            (reset),
    .reset_new        (reset_new),
    .num_obj          (num_obj),
    .region_x         (region_x),
    .region_y         (region_y),
    .region_valid     (region_valid),
    .region_rd_en     (region_rd_en),
    .cnn_rd_region    (cnn_rd_region),
    .cnn_region_done  (cnn_region_done),
    .cnn_region_valid (cnn_region_valid),
    .cnn_region_x_bit (cnn_region_x_bit),
    .cnn_region_y_bit (cnn_region_y_bit),
    .cnn_region_clk   (cnn_region_clk)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] exp_pair(input logic [8:0] a, input logic [8:0] b);
`ifdef RP2SERIAL_SORT_CORNERS_EN
    return (a <= b) ? {a, b} : {b, a};
`else
    return {a, b};
`endif
  endfunction

  // RP driver: offers 2*n words from wx/wy, follows region_rd_en.
  task automatic load_batch(input int n, output int hi, output int lat);
    int cnt;
    cnt = 0;
    hi  = 0;
    lat = 0;
    @(negedge clk);
    num_obj      = 5'(n);
    region_valid = 1'b1;
    region_x     = wx[0];
    region_y     = wy[0];
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (region_rd_en) begin
        if (cnt == 0) lat = c + 1;
        region_x = wx[cnt];
        region_y = wy[cnt];
        cnt++;
      end else if (cnt > 0) begin
        break;
      end
    end
    region_valid = 1'b0;
    hi = cnt;
  endtask

  // Serial receiver: waits (bounded) for valid, then samples 18 periods.
  task automatic recv_region(output logic [17:0] rx, output logic [17:0] ry,
                             output int wait_n, output int nvalid);
    rx = '0;
    ry = '0;
    wait_n = 0;
    nvalid = 0;
    while (!cnn_region_valid && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    for (int b = 0; b < 18; b++) begin
      if (cnn_region_valid) nvalid++;
      rx = {rx[16:0], cnn_region_x_bit};
      ry = {ry[16:0], cnn_region_y_bit};
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    int hi, lat, wn, nv, cnt_bad;
    logic [17:0] rx, ry;
    logic a, b;
    total = 0;
    bad = 0;
    reset = 1'b1;
    reset_new = 1'b0;
    num_obj = '0;
    region_x = '0;
    region_y = '0;
    region_valid = 1'b0;
    cnn_rd_region = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_done", 32'(cnn_region_done), 32'd1);
    check("rst_valid", 32'(cnn_region_valid), 32'd0);
    check("rst_rd_en", 32'(region_rd_en), 32'd0);
    check("rst_bits", 32'({cnn_region_x_bit, cnn_region_y_bit}), 32'd0);
    check("rst_rclk", 32'(cnn_region_clk), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    a = cnn_region_clk;
    @(negedge clk);
    b = cnn_region_clk;
    check("rclk_first", 32'(a), 32'd1);
    check("rclk_second", 32'(b), 32'd0);

    // load 4 regions
    wx[0] = 9'd10;  wy[0] = 9'd20;  wx[1] = 9'd30;  wy[1] = 9'd40;
    wx[2] = 9'd200; wy[2] = 9'd120; wx[3] = 9'd230; wy[3] = 9'd160;
    wx[4] = 9'd25;  wy[4] = 9'd25;  wx[5] = 9'd27;  wy[5] = 9'd27;
    wx[6] = 9'd88;  wy[6] = 9'd88;  wx[7] = 9'd90;  wy[7] = 9'd90;
    load_batch(4, hi, lat);
    check("load4_rd_en_cycles", 32'(hi), 32'd8);
    check("load4_rd_en_latency", 32'(lat), 32'd1);
    check("load4_done_low", 32'(cnn_region_done), 32'd0);
    check("load4_no_send_yet", 32'(cnn_region_valid), 32'd0);

    // stream the 4 regions with request held
    cnn_rd_region = 1'b1;
    recv_region(rx, ry, wn, nv);
    check("r0_valid_len", 32'(nv), 32'd18);
    check("r0_x", 32'(rx), 32'({9'd10, 9'd30}));
    check("r0_y", 32'(ry), 32'({9'd20, 9'd40}));
    check("r0_gap_valid", 32'(cnn_region_valid), 32'd0);
    check("r0_done", 32'(cnn_region_done), 32'd0);
    recv_region(rx, ry, wn, nv);
    check("r1_gap_len", 32'(wn), 32'd2);
    check("r1_valid_len", 32'(nv), 32'd18);
    check("r1_x", 32'(rx), 32'({9'd200, 9'd230}));
    check("r1_y", 32'(ry), 32'({9'd120, 9'd160}));
    recv_region(rx, ry, wn, nv);
    check("r2_gap_len", 32'(wn), 32'd2);
    check("r2_x", 32'(rx), 32'({9'd25, 9'd27}));
    check("r2_y", 32'(ry), 32'({9'd25, 9'd27}));
    check("r2_done", 32'(cnn_region_done), 32'd0);
    recv_region(rx, ry, wn, nv);
    check("r3_gap_len", 32'(wn), 32'd2);
    check("r3_x", 32'(rx), 32'({9'd88, 9'd90}));
    check("r3_y", 32'(ry), 32'({9'd88, 9'd90}));
    check("r3_done", 32'(cnn_region_done), 32'd1);
    check("r3_gap_valid", 32'(cnn_region_valid), 32'd0);

    // request with empty buffer
    cnt_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cnn_region_valid || !cnn_region_done) cnt_bad++;
    end
    check("empty_req_quiet", 32'(cnt_bad), 32'd0);

    // corner ordering
    wx[0] = 9'd30; wy[0] = 9'd40; wx[1] = 9'd10; wy[1] = 9'd20;
    load_batch(1, hi, lat);
    check("ord_rd_en_cycles", 32'(hi), 32'd2);
    recv_region(rx, ry, wn, nv);
    check("ord_valid_len", 32'(nv), 32'd18);
`ifdef RP2SERIAL_SORT_CORNERS_EN
    check("ord_x", 32'(rx), 32'({9'd10, 9'd30}));
    check("ord_y", 32'(ry), 32'({9'd20, 9'd40}));
`else
    check("ord_x", 32'(rx), 32'({9'd30, 9'd10}));
    check("ord_y", 32'(ry), 32'({9'd40, 9'd20}));
`endif
    check("ord_done", 32'(cnn_region_done), 32'd1);

    // soft reset mid-burst
    wx[0] = 9'd100; wy[0] = 9'd101; wx[1] = 9'd102; wy[1] = 9'd103;
    wx[2] = 9'd104; wy[2] = 9'd105; wx[3] = 9'd106; wy[3] = 9'd107;
    load_batch(2, hi, lat);
    wn = 0;
    while (!cnn_region_valid && wn < 200) begin
      @(negedge clk);
      wn++;
    end
    check("srst_burst_started", 32'(cnn_region_valid), 32'd1);
    repeat (5) @(negedge clk);
    reset_new = 1'b1;
    @(negedge clk);
    check("srst_valid", 32'(cnn_region_valid), 32'd0);
    check("srst_done", 32'(cnn_region_done), 32'd1);
    a = cnn_region_clk;
    reset_new = 1'b0;
    @(negedge clk);
    b = cnn_region_clk;
    check("srst_rclk_runs", 32'(a ^ b), 32'd1);
    cnt_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cnn_region_valid || !cnn_region_done) cnt_bad++;
    end
    check("srst_buffer_empty", 32'(cnt_bad), 32'd0);
    wx[0] = 9'd511; wy[0] = 9'd0; wx[1] = 9'd1; wy[1] = 9'd256;
    load_batch(1, hi, lat);
    check("srst_load_cycles", 32'(hi), 32'd2);
    recv_region(rx, ry, wn, nv);
    check("srst_valid_len", 32'(nv), 32'd18);
`ifdef RP2SERIAL_SORT_CORNERS_EN
    check("srst_x", 32'(rx), 32'({9'd1, 9'd511}));
`else
    check("srst_x", 32'(rx), 32'({9'd511, 9'd1}));
`endif
    check("srst_y", 32'(ry), 32'({9'd0, 9'd256}));
    check("srst_done_after", 32'(cnn_region_done), 32'd1);

    // num_obj above buffer depth: 17 offered, 16 kept
    for (int i = 0; i < 34; i++) begin
      wx[i] = 9'((i * 13 + 5) % 512);
      wy[i] = 9'((i * 29 + 3) % 512);
    end
    load_batch(17, hi, lat);
    check("ovf_rd_en_cycles", 32'(hi), 32'd34);
    for (int r = 0; r < 16; r++) begin
      recv_region(rx, ry, wn, nv);
      check($sformatf("ovf_r%0d_x", r), 32'(rx), 32'(exp_pair(wx[2*r], wx[2*r+1])));
      check($sformatf("ovf_r%0d_y", r), 32'(ry), 32'(exp_pair(wy[2*r], wy[2*r+1])));
    end
    check("ovf_done", 32'(cnn_region_done), 32'd1);
    cnt_bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cnn_region_valid) cnt_bad++;
    end
    check("ovf_no_17th", 32'(cnt_bad), 32'd0);

    cnn_rd_region = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
